// File: rtl/sd_reg_bus_bridge_if.sv
// Host-side request/response bus for the SD register bridge.
// The host drives req/we/addr/size/wdata; the bridge answers with ack/err/rdata.
interface sd_reg_bus_bridge_if;
    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [1:0]  host_size;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic        host_err;
    logic [31:0] host_rdata;

    modport master (
        output host_req, host_we, host_addr, host_size, host_wdata,
        input  host_ack, host_err, host_rdata
    );

    modport slave (
        input  host_req, host_we, host_addr, host_size, host_wdata,
        output host_ack, host_err, host_rdata
    );
endinterface

// File: rtl/sd_reg_bus_bridge.sv
// Host bus slave in front of the SD host register bank: decode, strobe, wait for ack, respond.
// Optional error log (err_addr/err_sticky) is built only when SD_REG_BRIDGE_ERRLOG_EN is defined.
module sd_reg_bus_bridge #(
    parameter int NREG        = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    sd_reg_bus_bridge_if.slave   host,
    output logic [NREG-1:0]      reg_wr_valid,
    output logic [31:0]          reg_wr_data,
    input  logic [NREG-1:0]      reg_ack,
    input  logic [NREG*32-1:0]   reg_rd_data,
    output logic [7:0]           err_addr,
    output logic                 err_sticky
);

    typedef enum logic [2:0] {IDLE, WSTB, WACK, RD, RESP, DONE} state_t;

    localparam logic [1:0] SZ8  = 2'd0;
    localparam logic [1:0] SZ16 = 2'd1;
    localparam logic [1:0] SZ32 = 2'd2;
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [2:0]  slot;
    logic [1:0]  size;
    logic [7:0]  cnt;
    logic        dec_legal;
    logic [2:0]  dec_slot;

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ8:     size_mask = 32'h0000_00FF;
            SZ16:    size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Fixed register map: an access is legal only at a slot's start address with its exact size.
    always_comb begin
        dec_legal = 1'b0;
        dec_slot  = 3'd0;
        case (host.host_addr)
            8'h00: begin dec_slot = 3'd0; dec_legal = (host.host_size == SZ32); end
            8'h04: begin dec_slot = 3'd1; dec_legal = (host.host_size == SZ16); end
            8'h06: begin dec_slot = 3'd2; dec_legal = (host.host_size == SZ16); end
            8'h08: begin dec_slot = 3'd3; dec_legal = (host.host_size == SZ32); end
            8'h0C: begin dec_slot = 3'd4; dec_legal = (host.host_size == SZ16); end
            8'h0E: begin dec_slot = 3'd5; dec_legal = (host.host_size == SZ16); end
            8'h28: begin dec_slot = 3'd6; dec_legal = (host.host_size == SZ8);  end
            8'h2F: begin dec_slot = 3'd7; dec_legal = (host.host_size == SZ8);  end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            slot            <= 3'd0;
            size            <= 2'd0;
            cnt             <= 8'd0;
            host.host_ack   <= 1'b0;
            host.host_err   <= 1'b0;
            host.host_rdata <= 32'd0;
            reg_wr_valid    <= '0;
            reg_wr_data     <= 32'd0;
        end else begin
            host.host_ack <= 1'b0;
            host.host_err <= 1'b0;
            reg_wr_valid  <= '0;
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (host.host_req) begin
                        if (!dec_legal) begin
                            host.host_ack <= 1'b1;
                            host.host_err <= 1'b1;
                            state         <= RESP;
                        end else begin
                            slot <= dec_slot;
                            size <= host.host_size;
                            if (host.host_we) begin
                                reg_wr_data  <= host.host_wdata & size_mask(host.host_size);
                                reg_wr_valid <= NREG'(1) << dec_slot;
                                state        <= WSTB;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                WSTB: begin
                    cnt   <= 8'd0;
                    state <= WACK;
                end
                WACK: begin
                    if (reg_ack[slot]) begin
                        host.host_ack <= 1'b1;
                        state         <= RESP;
                    end else if (cnt == TIMEOUT_LAST) begin
                        host.host_ack <= 1'b1;
                        host.host_err <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RD: begin
                    if (reg_ack[slot]) begin
                        host.host_rdata <= reg_rd_data[{slot, 5'd0} +: 32] & size_mask(size);
                        host.host_ack   <= 1'b1;
                        state           <= RESP;
                    end else if (cnt == TIMEOUT_LAST) begin
                        host.host_rdata <= 32'd0;
                        host.host_ack   <= 1'b1;
                        host.host_err   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: state <= DONE;
                // A held request must be released before the next access is accepted.
                DONE: if (!host.host_req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SD_REG_BRIDGE_ERRLOG_EN
    // The host still holds the faulting address during the error response cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr   <= 8'd0;
            err_sticky <= 1'b0;
        end else if (host.host_ack && host.host_err) begin
            err_addr   <= host.host_addr;
            err_sticky <= 1'b1;
        end
    end
`else
    assign err_addr   = 8'd0;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_sd_reg_bus_bridge.sv
// Randomized self-checking bench for sd_reg_bus_bridge against a transaction-level model.
// Expected latency, error, strobe and read data are derived from the register map and timing rules.
module tb_sd_reg_bus_bridge;

    localparam int T = 15;

    logic         clk;
    logic         reset;
    logic [7:0]   reg_wr_valid;
    logic [31:0]  reg_wr_data;
    logic [7:0]   reg_ack;
    logic [255:0] rd_lanes;
    logic [7:0]   err_addr;
    logic         err_sticky;

    sd_reg_bus_bridge_if bus();

    sd_reg_bus_bridge #(.NREG(8), .ACK_TIMEOUT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .host         (bus),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_data  (reg_wr_data),
        .reg_ack      (reg_ack),
        .reg_rd_data  (rd_lanes),
        .err_addr     (err_addr),
        .err_sticky   (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          num_checks = 0;
    int          num_fails  = 0;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wr_data;
    logic [7:0]  exp_err_addr;
    logic        exp_sticky;

    logic [7:0] slot_addr [8] = '{8'h00, 8'h04, 8'h06, 8'h08, 8'h0C, 8'h0E, 8'h28, 8'h2F};
    logic [1:0] slot_size [8] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] width_mask(input logic [1:0] sz);
        if (sz == 2'd0) return 32'h0000_00FF;
        if (sz == 2'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic checkErrLog();
`ifdef SD_REG_BRIDGE_ERRLOG_EN
        checkOutput("err_addr", 32'(err_addr), 32'(exp_err_addr));
        checkOutput("err_sticky", 32'(err_sticky), 32'(exp_sticky));
`else
        checkOutput("err_addr", 32'(err_addr), 32'd0);
        checkOutput("err_sticky", 32'(err_sticky), 32'd0);
`endif
    endtask

    task automatic resetModel();
        exp_rdata    = 32'd0;
        exp_wr_data  = 32'd0;
        exp_err_addr = 8'd0;
        exp_sticky   = 1'b0;
    endtask

    // One full host transaction: request, wait for ack, optionally hold req, then release.
    task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [1:0] size,
                                 input logic [31:0] wdata, input int ack_delay, input int hold_cycles);
        bit          legal = 0;
        bit          exp_err;
        int          slot = 0;
        int          first;
        int          exp_lat;
        int          cyc = 0;
        int          ack_cycle = -1;
        int          strobe_count = 0;
        int          strobe_cycle = 0;
        int          extra_events = 0;
        logic [7:0]  strobe_val = 8'd0;
        logic [31:0] strobe_data = 32'd0;
        logic [31:0] got_rdata = 32'd0;
        logic        got_err = 1'b0;
        logic [31:0] mask;

        for (int i = 0; i < 8; i++)
            if (slot_addr[i] == addr && slot_size[i] == size) begin
                legal = 1;
                slot  = i;
            end
        mask = width_mask(size);

        if (!legal) begin
            exp_lat = 1;
            exp_err = 1;
        end else if (we) begin
            first   = (ack_delay < 2) ? 2 : ack_delay;
            exp_err = (first > T + 1);
            exp_lat = exp_err ? T + 2 : first + 1;
        end else begin
            first   = (ack_delay < 1) ? 1 : ack_delay;
            exp_err = (first > T);
            exp_lat = exp_err ? T + 1 : first + 1;
        end

        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = addr;
        bus.host_size  = size;
        bus.host_wdata = wdata;
        reg_ack        = (ack_delay == 0) ? 8'hFF : 8'h00;

        while (ack_cycle < 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            reg_ack = (cyc >= ack_delay) ? 8'hFF : 8'h00;
            if (reg_wr_valid != 8'd0) begin
                strobe_count++;
                strobe_val   = reg_wr_valid;
                strobe_cycle = cyc;
                strobe_data  = reg_wr_data;
            end
            if (bus.host_ack) begin
                ack_cycle = cyc;
                got_err   = bus.host_err;
                got_rdata = bus.host_rdata;
            end
        end
        if (ack_cycle < 0) checkOutput("ack_seen", 32'd0, 32'd1);

        for (int h = 0; h < hold_cycles; h++) begin
            @(posedge clk); #1;
            if (bus.host_ack || reg_wr_valid != 8'd0) extra_events++;
        end
        bus.host_req = 1'b0;
        reg_ack      = 8'h00;
        for (int h = 0; h < 2; h++) begin
            @(posedge clk); #1;
            if (bus.host_ack || reg_wr_valid != 8'd0) extra_events++;
        end

        if (legal && !we) exp_rdata = exp_err ? 32'd0 : (rd_lanes[slot*32 +: 32] & mask);
        if (legal && we) exp_wr_data = wdata & mask;
        if (exp_err) begin
            exp_err_addr = addr;
            exp_sticky   = 1'b1;
        end

        checkOutput($sformatf("latency@%02h", addr), 32'(ack_cycle), 32'(exp_lat));
        checkOutput($sformatf("err@%02h", addr), 32'(got_err), 32'(exp_err));
        checkOutput($sformatf("rdata@%02h", addr), got_rdata, exp_rdata);
        checkOutput("rdata_hold", bus.host_rdata, exp_rdata);
        checkOutput("strobe_count", 32'(strobe_count), (legal && we) ? 32'd1 : 32'd0);
        if (legal && we) begin
            checkOutput("strobe_slot", 32'(strobe_val), 32'd1 << slot);
            checkOutput("strobe_cycle", 32'(strobe_cycle), 32'd1);
            checkOutput("strobe_data", strobe_data, exp_wr_data);
        end
        checkOutput("wr_data_hold", reg_wr_data, exp_wr_data);
        checkOutput("extra_events", 32'(extra_events), 32'd0);
        checkErrLog();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack"}, 32'(bus.host_ack), 32'd0);
        checkOutput({tag, "_err"}, 32'(bus.host_err), 32'd0);
        checkOutput({tag, "_rdata"}, bus.host_rdata, 32'd0);
        checkOutput({tag, "_wr_valid"}, 32'(reg_wr_valid), 32'd0);
        checkOutput({tag, "_wr_data"}, reg_wr_data, 32'd0);
        checkOutput({tag, "_err_addr"}, 32'(err_addr), 32'd0);
        checkOutput({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
    endtask

    initial begin
        int acks_seen;
        int r;
        int d;
        logic [7:0] a;
        logic [1:0] s;

        reset          = 1'b1;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = 8'd0;
        bus.host_size  = 2'd0;
        bus.host_wdata = 32'd0;
        reg_ack        = 8'h00;
        rd_lanes       = '0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkAllZero("reset");

        for (int i = 0; i < 8; i++) rd_lanes[i*32 +: 32] = $urandom;
        applyStimulus(1'b1, 8'h08, 2'd2, 32'hDEADBEEF, 0, 0);
        applyStimulus(1'b1, 8'h28, 2'd0, 32'h12345678, 0, 0);
        rd_lanes[2*32 +: 32] = 32'hFFFFA5A5;
        applyStimulus(1'b0, 8'h06, 2'd1, 32'd0, 0, 0);
        applyStimulus(1'b1, 8'h05, 2'd1, 32'hCAFEF00D, 0, 0);
        applyStimulus(1'b1, 8'h00, 2'd1, 32'hCAFEF00D, 0, 0);
        applyStimulus(1'b1, 8'h0E, 2'd1, 32'h0BADC0DE, 999, 5);
        applyStimulus(1'b0, 8'h2F, 2'd0, 32'd0, 999, 2);
        applyStimulus(1'b0, 8'h00, 2'd2, 32'd0, 3, 1);

        // Abort a write in its acknowledge wait with reset.
        acks_seen      = 0;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 8'h00;
        bus.host_size  = 2'd2;
        bus.host_wdata = 32'h5A5A1234;
        reg_ack        = 8'h00;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.host_ack) acks_seen++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        if (bus.host_ack) acks_seen++;
        checkAllZero("abort");
        bus.host_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.host_ack) acks_seen++;
        end
        checkOutput("abort_acks", 32'(acks_seen), 32'd0);
        resetModel();
        applyStimulus(1'b1, 8'h0C, 2'd1, 32'h87654321, 0, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                r = $urandom_range(0, 7);
                a = slot_addr[r];
                s = slot_size[r];
            end else begin
                a = 8'($urandom_range(0, 63));
                s = 2'($urandom_range(0, 3));
            end
            for (int i = 0; i < 8; i++) rd_lanes[i*32 +: 32] = $urandom;
            d = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : 30;
            applyStimulus(1'($urandom_range(0, 1)), a, s, $urandom, d, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
